modport_tff: RTL and testbench



---
 rtl/modport_tff.sv | 22 ++
 tb/tb_modport_tff.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/modport_tff.sv
// Bank of WIDTH independent toggle flip-flops: each set bit of t inverts the
// matching out bit on the rising clock edge; synchronous reset has priority.
module modport_tff #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] out
);

  // Reset discards any toggle requested on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= RESET_VAL;
    end else begin
      out <= out ^ t;
    end
  end

endmodule

// File: tb/tb_modport_tff.sv
// Self-checking bench: directed vector tables for a 1-bit and a 4-bit bank,
// then randomized stimulus checked against a toggle-count parity model.
module tb_modport_tff;

  localparam logic [3:0] RV4 = 4'b1010;

  typedef struct {
    logic       rst_n;
    logic [3:0] t;
    logic [3:0] exp;
  } vec_t;

  logic       clk;
  logic       rst1_n;
  logic       t1;
  logic       out1;
  logic       rst4_n;
  logic [3:0] t4;
  logic [3:0] out4;

  int vectors;
  int miscompares;

  modport_tff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk  (clk),
    .rst_n(rst1_n),
    .t    (t1),
    .out  (out1)
  );

  modport_tff #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
    .clk  (clk),
    .rst_n(rst4_n),
    .t    (t4),
    .out  (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Inputs are applied between edges; outputs are read at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t v1[$];
  vec_t v4[$];

  function automatic vec_t mk(input logic r, input logic [3:0] t, input logic [3:0] e);
    vec_t v;
    v.rst_n = r;
    v.t     = t;
    v.exp   = e;
    return v;
  endfunction

  // Reference model: out = RESET_VAL ^ parity of toggles seen since last reset.
  int cnt1;
  int cnt4[4];

  initial begin
    logic [3:0] exp4;
    logic       exp1;
    vectors     = 0;
    miscompares = 0;

    // 1-bit: reset with t=1, hold, toggle stream, mixed pattern, mid-run reset
    for (int i = 0; i < 3; i++) v1.push_back(mk(1'b0, 4'd1, 4'd0));
    for (int i = 0; i < 4; i++) v1.push_back(mk(1'b1, 4'd0, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));
    v1.push_back(mk(1'b1, 4'd1, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));
    v1.push_back(mk(1'b1, 4'd1, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));
    v1.push_back(mk(1'b1, 4'd1, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));
    v1.push_back(mk(1'b1, 4'd0, 4'd1));
    v1.push_back(mk(1'b1, 4'd0, 4'd1));
    v1.push_back(mk(1'b1, 4'd1, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));
    v1.push_back(mk(1'b1, 4'd0, 4'd1));
    v1.push_back(mk(1'b0, 4'd1, 4'd0));
    v1.push_back(mk(1'b1, 4'd1, 4'd1));

    v4.push_back(mk(1'b0, 4'b1111, RV4));
    v4.push_back(mk(1'b0, 4'b0101, RV4));
    v4.push_back(mk(1'b1, 4'b0110, 4'b1100));
    v4.push_back(mk(1'b1, 4'b1111, 4'b0011));
    v4.push_back(mk(1'b1, 4'b0000, 4'b0011));
    v4.push_back(mk(1'b1, 4'b0000, 4'b0011));
    v4.push_back(mk(1'b0, 4'b1001, RV4));
    v4.push_back(mk(1'b1, 4'b1001, 4'b0011));

    rst1_n = 1'b0;
    t1     = 1'b1;
    rst4_n = 1'b0;
    t4     = 4'b0000;

    foreach (v1[i]) begin
      rst1_n = v1[i].rst_n;
      t1     = v1[i].t[0];
      step();
      check("w1_vec", i, {3'b000, out1}, v1[i].exp);
    end

    foreach (v4[i]) begin
      rst4_n = v4[i].rst_n;
      t4     = v4[i].t;
      step();
      check("w4_vec", i, out4, v4[i].exp);
    end

    // Randomized phase: start both banks from a known reset
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    t1     = 1'b1;
    t4     = 4'b1111;
    step();
    cnt1 = 0;
    for (int b = 0; b < 4; b++) cnt4[b] = 0;

    for (int i = 0; i < 300; i++) begin
      rst1_n = ($urandom_range(15) != 0);
      rst4_n = ($urandom_range(15) != 0);
      t1     = 1'($urandom_range(1));
      t4     = 4'($urandom_range(15));
      if (!rst1_n) cnt1 = 0;
      else if (t1) cnt1 = cnt1 + 1;
      for (int b = 0; b < 4; b++) begin
        if (!rst4_n) cnt4[b] = 0;
        else if (t4[b]) cnt4[b] = cnt4[b] + 1;
      end
      exp1 = 1'((cnt1 % 2) != 0);
      for (int b = 0; b < 4; b++) exp4[b] = RV4[b] ^ ((cnt4[b] % 2) != 0);
      step();
      check("w1_rand", i, {3'b000, out1}, {3'b000, exp1});
      check("w4_rand", i, out4, exp4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
